snake_move_register: RTL and testbench
======================================

# snake_move_register

Move-history shift register for the snake game datapath. It records the direction code of every move the snake makes, newest first, in a 64-entry × 3-bit shift register. The game controller pushes one direction per step while `shift` is high. The renderer/collision logic reads any stored entry by index through `pos`, so it can walk the snake body segment by segment.

## Interface
Parameters: none (depth 64 and entry width 3 are fixed).

- `clk` input 1: single system clock; all state changes on the rising edge.
- `reset` input 1: synchronous, active-low reset.
- `shift` input 1: 1 = push `load` into the history on this edge; 0 = hold contents.
- `load` input 3: direction code to push. The block treats it as opaque and stores all 3 bits.
- `pos` input 6: read index; 0 = newest entry, 63 = oldest.
- `out_head` output 3: newest stored entry (entry 0).
- `out_pos` output 3: entry selected by `pos`.

## Operation
- Storage: `entry[0..63]`, each 3 bits; `entry[0]` is the newest.
- Rising edge with `reset`=0:
  - all 64 entries clear to 3'b000;
  - this takes priority over `shift`.
- Rising edge with `reset`=1 and `shift`=1:
  - `entry[0]` <= `load`;
  - `entry[i]` <= `entry[i-1]` for i = 1..63;
  - the old `entry[63]` is discarded; there is no overflow flag and no wrap.
- Rising edge with `reset`=1 and `shift`=0: all entries hold.
- `out_head` = `entry[0]`, driven continuously from the register.
- `out_pos` = `entry[pos]`, a combinational 64:1 mux of 3-bit entries.
  - Every 6-bit `pos` value is a legal index; there is no out-of-range case.
- `pos` is ignored for writes. Reads are legal whatever the value of `shift`.
- Codes 3'b100–3'b111 are stored and returned unchanged.
- The block keeps no length counter. Entries never pushed since reset read as 3'b000.

## Timing
- Write latency: 1 cycle. A value pushed at edge N appears on `out_head` immediately after edge N.
  - After edge N it is read at `pos`=0; after k further pushes it is read at `pos`=k.
- Read latency: 0 cycles (combinational from `pos` and the register state).
  - In a cycle with `shift`=1, `out_pos`/`out_head` show pre-edge contents until the edge.
- Reset: synchronous only. `reset` going low between edges has no effect until the next rising edge.
  - After that edge: `out_head`=0, and `out_pos`=0 for every `pos`.
- Reset during a push sequence (`shift`=1 and `reset`=0 on the same edge): the clear wins and `load` is not stored.
- Before the first reset edge, contents are undefined. Benches must apply reset before checking.
- There is no handshake. One push per cycle is sustainable indefinitely.

## Test plan
- Reset:
  - Stimulus: preload arbitrary data, drive `reset`=0 for one edge, then `reset`=1, `shift`=0.
  - Required: `out_head`=0 and `out_pos`=0 for `pos`=0..63.
- Full fill and readback:
  - Stimulus: with `shift`=1, push `load`=0,1,2,3 repeated 16 times (64 edges); then set `shift`=0 and sweep `pos`=0..63.
  - Required: after the last push `out_head`=3; `out_pos` = 3 − (`pos` mod 4), e.g. `pos`=0→3, 1→2, 2→1, 3→0, 63→0.
- Hold:
  - Stimulus: after the fill, run 64 edges with `shift`=0 and `load` toggling.
  - Required: contents unchanged and the sweep repeats the identical values.
- Overflow:
  - Stimulus: after the fill, push one extra `load`=3'b101.
  - Required: `out_head`=5, `pos`=1 reads 3, `pos`=63 reads 1, and the previous oldest 0 is gone.
- Reset priority:
  - Stimulus: mid-sequence, assert `reset`=0 with `shift`=1, `load`=2 for one edge.
  - Required: every entry reads 0, including `out_head`.
- Partial fill:
  - Stimulus: after reset, push 7 then 6.
  - Required: `pos`=0→6, `pos`=1→7, `pos`=2..63→0.

Source files
------------

// File: rtl/snake_move_register_if.sv
// Signal bundle between the snake game controller and the move-history register.
// There is no handshake: a push happens on every rising edge where shift is 1,
// and reads are purely combinational, so one push per cycle is always accepted.
interface snake_move_register_if;
  logic       shift;     // 1 = push load into the history on this edge
  logic [2:0] load;      // direction code to push, stored as-is
  logic [5:0] pos;       // read index, 0 = newest, 63 = oldest
  logic [2:0] out_head;  // newest entry
  logic [2:0] out_pos;   // entry selected by pos

  // Controller side: drives pushes and read index, observes the history.
  modport master (
    output shift,
    output load,
    output pos,
    input  out_head,
    input  out_pos
  );

  // Register side: accepts pushes, returns stored entries.
  modport slave (
    input  shift,
    input  load,
    input  pos,
    output out_head,
    output out_pos
  );
endinterface

// File: rtl/snake_move_register.sv
// Move-history shift register: 64 entries of 3-bit direction codes, newest
// first. Entry 0 sits in the low 3 bits of the packed vector so a push is a
// single concatenation and the oldest entry falls off the top.
module snake_move_register (
  input  logic                        clk,
  input  logic                        reset,
  snake_move_register_if.slave        bus
);

  localparam int DEPTH = 64;

  // entry[0] is the newest move, entry[63] the oldest.
  logic [DEPTH-1:0][2:0] entry;

  // Synchronous clear wins over a push on the same edge; otherwise push or hold.
  always_ff @(posedge clk) begin
    if (!reset) begin
      entry <= '0;
    end else if (bus.shift) begin
      entry <= {entry[DEPTH-2:0], bus.load};
    end
  end

  // Reads are combinational so the renderer sees pre-edge contents during a push.
  assign bus.out_head = entry[0];
  assign bus.out_pos  = entry[bus.pos];

endmodule

// File: tb/tb_snake_move_register.sv
// Directed bench for the move-history register. Inputs change on the falling
// edge; outputs are sampled 1 ns after the falling edge, away from the active edge.
module tb_snake_move_register;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  logic [2:0] exp_q[$];
  logic [2:0] model [64];

  snake_move_register_if bus ();

  snake_move_register dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "time limit");
  end

  // Driver tasks
  task automatic model_clear();
    for (int i = 0; i < 64; i++) model[i] = 3'd0;
  endtask

  task automatic model_push(input logic [2:0] v);
    for (int i = 63; i > 0; i--) model[i] = model[i-1];
    model[0] = v;
  endtask

  task automatic do_reset(input logic sh, input logic [2:0] ld);
    @(negedge clk);
    reset     = 1'b0;
    bus.shift = sh;
    bus.load  = ld;
    @(posedge clk);
    model_clear();
    @(negedge clk);
    reset     = 1'b1;
    bus.shift = 1'b0;
  endtask

  task automatic push(input logic [2:0] v);
    @(negedge clk);
    bus.shift = 1'b1;
    bus.load  = v;
    @(posedge clk);
    model_push(v);
  endtask

  task automatic stop_shift();
    @(negedge clk);
    bus.shift = 1'b0;
  endtask

  // Scoreboard: expected pushed on drive, popped and compared on sample
  task automatic compare(input string tag, input logic [2:0] got);
    logic [2:0] e;
    e = exp_q.pop_front();
    checks++;
    assert (got === e) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, e);
    end
  endtask

  task automatic expect_pos(input string tag, input logic [5:0] p, input logic [2:0] exp);
    @(negedge clk);
    exp_q.push_back(exp);
    bus.pos = p;
    #1;
    compare($sformatf("%s pos=%0d", tag, p), bus.out_pos);
  endtask

  task automatic expect_head(input string tag, input logic [2:0] exp);
    @(negedge clk);
    exp_q.push_back(exp);
    #1;
    compare($sformatf("%s head", tag), bus.out_head);
  endtask

  // Directed sequence
  initial begin
    logic [2:0] r;
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    bus.shift = 1'b0;
    bus.load  = 3'd0;
    bus.pos   = 6'd0;
    model_clear();

    // Initial reset, then preload arbitrary data and clear it
    do_reset(1'b0, 3'd0);
    for (int i = 0; i < 10; i++) push(3'($urandom_range(1, 7)));
    stop_shift();
    do_reset(1'b0, 3'd0);
    expect_head("reset", 3'd0);
    for (int p = 0; p < 64; p++) expect_pos("reset", 6'(p), 3'd0);

    // Full fill with 0,1,2,3 repeated
    for (int i = 0; i < 64; i++) push(3'(i % 4));
    stop_shift();
    expect_head("fill", 3'd3);
    for (int p = 0; p < 64; p++) expect_pos("fill", 6'(p), 3'(3 - (p % 4)));

    // Hold for 64 edges with load toggling
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      bus.load = 3'(i);
    end
    expect_head("hold", 3'd3);
    for (int p = 0; p < 64; p++) expect_pos("hold", 6'(p), 3'(3 - (p % 4)));

    // Overflow push; head shows pre-edge value while shift is high
    @(negedge clk);
    bus.shift = 1'b1;
    bus.load  = 3'b101;
    exp_q.push_back(3'd3);
    #1;
    compare("pre-edge head", bus.out_head);
    @(posedge clk);
    model_push(3'b101);
    stop_shift();
    expect_head("overflow", 3'd5);
    expect_pos("overflow", 6'd1, 3'd3);
    expect_pos("overflow", 6'd62, 3'd2);
    expect_pos("overflow", 6'd63, 3'd1);

    // Random pushes checked against the history model
    for (int i = 0; i < 20; i++) begin
      r = 3'($urandom_range(0, 7));
      push(r);
    end
    stop_shift();
    expect_head("random", model[0]);
    for (int p = 0; p < 64; p++) expect_pos("random", 6'(p), model[p]);

    // Reset during a push: clear wins, load not stored
    push(3'd6);
    push(3'd4);
    do_reset(1'b1, 3'd2);
    expect_head("reset prio", 3'd0);
    for (int p = 0; p < 64; p++) expect_pos("reset prio", 6'(p), 3'd0);

    // Partial fill
    push(3'd7);
    push(3'd6);
    stop_shift();
    expect_head("partial", 3'd6);
    expect_pos("partial", 6'd0, 3'd6);
    expect_pos("partial", 6'd1, 3'd7);
    for (int p = 2; p < 64; p++) expect_pos("partial", 6'(p), 3'd0);

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
